// File: rtl/cnn_pkg.sv
// Shared constants, lane-array type and FSM states for the CNN feature-map front end.
package cnn_pkg;

  localparam int DW = 16;
  localparam int K  = 5;

  typedef logic [DW-1:0] lanes_t [K*K];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage; the old value at addr is visible while the new one is written.
module line_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [DEPTH];

  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= din;
    end
  end

endmodule

// File: rtl/ifmap_window_gen.sv
// Turns a raster pixel stream into stride-1 KxK windows, one window per qualifying pixel.
module ifmap_window_gen #(
  parameter int DW    = cnn_pkg::DW,
  parameter int K     = cnn_pkg::K,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           start,
  input  logic [DW-1:0]  pix_in,
  input  logic           pix_vld,
  output logic           pix_rdy,
  output logic [DW-1:0]  data_out [K*K],
  output logic           fifo_en,
  output logic [K*K-1:0] out_vld,
  output logic           busy,
  output logic           frame_done
);
  import cnn_pkg::*;

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          fifo_en_q, fifo_en_d;
  logic [DW-1:0] win_q  [K][K];
  logic [DW-1:0] win_d  [K][K];
  logic [DW-1:0] dout_q [K*K];
  logic [DW-1:0] dout_d [K*K];
  logic [DW-1:0] lb_out [K-1];
  logic [DW-1:0] new_col [K];
  logic          accept;
  logic          last_pix;
  logic          win_ready;

  // Line buffer 0 holds the previous row; each buffer feeds the next, older one.
  for (genvar gi = 0; gi < K-1; gi++) begin : g_lb
    logic [DW-1:0] lb_in;
    if (gi == 0) begin : g_first
      assign lb_in = pix_in;
    end else begin : g_chain
      assign lb_in = lb_out[gi-1];
    end
    line_buffer #(
      .DW    (DW),
      .DEPTH (IMG_W),
      .AW    (CW)
    ) u_line_buffer (
      .clk   (clk),
      .wr_en (accept),
      .addr  (col_q),
      .din   (lb_in),
      .dout  (lb_out[gi])
    );
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_col
    if (gi == K-1) begin : g_pix
      assign new_col[gi] = pix_in;
    end else begin : g_lbuf
      assign new_col[gi] = lb_out[K-2-gi];
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    pix_rdy   = (state_q == ST_FILL) || (state_q == ST_RUN);
    accept    = pix_vld && pix_rdy;
    last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    win_ready = (row_q >= ROW_WIN) && (col_q >= COL_WIN);
    fifo_en_d = accept && win_ready;

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_FILL: begin
        if (accept && last_pix) begin
          state_d = ST_DONE;
        end else if (accept && win_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && last_pix) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = start ? ST_FILL : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Window shifts left on every accepted pixel; data_out only captures qualifying windows.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K-1; j++) begin
        win_d[i][j] = accept ? win_q[i][j+1] : win_q[i][j];
      end
      win_d[i][K-1] = accept ? new_col[i] : win_q[i][K-1];
    end
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        dout_d[i*K+j] = fifo_en_d ? win_d[i][j] : dout_q[i*K+j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      fifo_en_q <= 1'b0;
      for (int n = 0; n < K*K; n++) begin
        dout_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      fifo_en_q <= fifo_en_d;
      for (int n = 0; n < K*K; n++) begin
        dout_q[n] <= dout_d[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_q[i][j] <= win_d[i][j];
      end
    end
  end

  assign data_out   = dout_q;
  assign fifo_en    = fifo_en_q;
  assign out_vld    = {(K*K){fifo_en_q}};
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ifmap_window_gen.sv
// Directed bench for ifmap_window_gen on an 8x6 frame whose pixel value is row*16+col.
module tb_ifmap_window_gen;
  import cnn_pkg::*;

  localparam int TW  = 8;
  localparam int TH  = 6;
  localparam int NL  = K*K;
  localparam int NPX = TW*TH;
  localparam int STROBES_PER_FRAME = (TW-K+1)*(TH-K+1);

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [DW-1:0] pix_in;
  logic          pix_vld;
  logic          pix_rdy;
  logic [DW-1:0] data_out [NL];
  logic          fifo_en;
  logic [NL-1:0] out_vld;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int strobes  = 0;
  int dones    = 0;

  lanes_t exp_win;
  logic   exp_fe   = 1'b0;
  logic   exp_done = 1'b0;

  always #5 clk = ~clk;

  ifmap_window_gen #(
    .DW    (DW),
    .K     (K),
    .IMG_W (TW),
    .IMG_H (TH)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .pix_in     (pix_in),
    .pix_vld    (pix_vld),
    .pix_rdy    (pix_rdy),
    .data_out   (data_out),
    .fifo_en    (fifo_en),
    .out_vld    (out_vld),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs for the next cycle come from what was offered on the previous one.
  always @(negedge clk) begin : monitor
    int r, c;
    check_val("fifo_en", 32'(fifo_en), 32'(exp_fe));
    check_val("out_vld", 32'(out_vld), 32'({NL{exp_fe}}));
    check_val("frame_done", 32'(frame_done), 32'(exp_done));
    for (int n = 0; n < NL; n++) begin
      check_val($sformatf("lane%0d", n), 32'(data_out[n]), 32'(exp_win[n]));
    end
    if (fifo_en) strobes++;
    if (frame_done) dones++;
    if (exp_fe) begin
      $display("window %0d: lane0=0x%04h lane24=0x%04h", strobes, data_out[0], data_out[NL-1]);
    end

    exp_fe   = 1'b0;
    exp_done = 1'b0;
    if (nrst) begin
      for (int n = 0; n < NL; n++) exp_win[n] = '0;
    end else if (pix_vld && pix_rdy) begin
      r = int'(pix_in[7:4]);
      c = int'(pix_in[3:0]);
      if (r >= K-1 && c >= K-1) begin
        exp_fe = 1'b1;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            exp_win[i*K+j] = DW'(((r-K+1+i) * 16) + (c-K+1+j));
          end
        end
      end
      if (r == TH-1 && c == TW-1) exp_done = 1'b1;
    end
  end

  // Streams pixels 0..max_pix-1 in raster order, holding each until accepted.
  task automatic run_frame(input int bubble, input int max_pix, input int mid_start, input bit do_start);
    int idx = 0;
    int cyc = 0;
    bit acc;
    bit pulsed = 1'b0;
    if (do_start) start = 1'b1;
    while (idx < max_pix && cyc < 2000) begin
      pix_in  = DW'(((idx / TW) * 16) + (idx % TW));
      pix_vld = ($urandom_range(99) >= bubble);
      if (idx == mid_start && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
      acc = pix_vld && pix_rdy;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (cyc == 0 && do_start) begin
        check_val("busy_after_start", 32'(busy), 32'd1);
        check_val("rdy_after_start", 32'(pix_rdy), 32'd1);
      end
      if (acc) idx++;
      cyc++;
    end
    pix_vld = 1'b0;
    check_val("frame_timeout", 32'(cyc < 2000), 32'd1);
  endtask

  task automatic check_done_cycle();
    check_val("done_busy", 32'(busy), 32'd1);
    check_val("done_rdy", 32'(pix_rdy), 32'd0);
    check_val("done_pulse", 32'(frame_done), 32'd1);
  endtask

  task automatic check_counts(input string tag, input int s0, input int d0, input int frames);
    check_val({tag, "_strobes"}, 32'(strobes - s0), 32'(frames * STROBES_PER_FRAME));
    check_val({tag, "_dones"}, 32'(dones - d0), 32'(frames));
  endtask

  initial begin
    int s0, d0;
    for (int n = 0; n < NL; n++) exp_win[n] = '0;
    nrst    = 1'b1;
    start   = 1'b0;
    pix_vld = 1'b0;
    pix_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rdy", 32'(pix_rdy), 32'd0);
    check_val("rst_fifo_en", 32'(fifo_en), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    nrst = 1'b0;

    // Pixels offered in IDLE must be refused.
    pix_in  = 16'hABCD;
    pix_vld = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("idle_rdy", 32'(pix_rdy), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
    end
    pix_vld = 1'b0;

    s0 = strobes; d0 = dones;
    run_frame(0, NPX, -1, 1'b1);
    check_done_cycle();
    @(posedge clk); #1;
    check_val("ramp_idle_busy", 32'(busy), 32'd0);
    check_counts("ramp", s0, d0, 1);

    s0 = strobes; d0 = dones;
    run_frame(50, NPX, -1, 1'b1);
    check_done_cycle();
    @(posedge clk); #1;
    check_counts("bubble", s0, d0, 1);

    // Reset in the middle of a frame, then a clean frame.
    run_frame(0, 20, -1, 1'b1);
    nrst = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    check_val("mid_rst_fifo_en", 32'(fifo_en), 32'd0);
    check_val("mid_rst_out_vld", 32'(out_vld), 32'd0);
    check_val("mid_rst_done", 32'(frame_done), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_rdy", 32'(pix_rdy), 32'd0);
    for (int n = 0; n < NL; n++) begin
      check_val("mid_rst_lane", 32'(data_out[n]), 32'd0);
    end
    @(posedge clk); #1;
    s0 = strobes; d0 = dones;
    run_frame(0, NPX, -1, 1'b1);
    check_done_cycle();
    @(posedge clk); #1;
    check_counts("after_rst", s0, d0, 1);

    // start pulse while in RUN must be ignored.
    s0 = strobes; d0 = dones;
    run_frame(0, NPX, 40, 1'b1);
    check_done_cycle();
    @(posedge clk); #1;
    check_counts("run_start", s0, d0, 1);

    // Back-to-back frames: start raised during the DONE cycle.
    s0 = strobes; d0 = dones;
    run_frame(0, NPX, -1, 1'b1);
    check_done_cycle();
    run_frame(50, NPX, -1, 1'b1);
    check_done_cycle();
    @(posedge clk); #1;
    check_val("b2b_idle_busy", 32'(busy), 32'd0);
    check_counts("b2b", s0, d0, 2);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
